// File: rtl/vx_fu_lane_dispatcher.sv
// Serializes a full-warp FU instruction into NUM_LANES-wide packets tagged pid/sop/eop.
// Lane blocks with an empty thread mask are skipped; an all-empty mask still emits one packet.
module vx_fu_lane_dispatcher #(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned NUM_LANES   = 1,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NW_WIDTH    = 2,
    parameter int unsigned UUID_WIDTH  = 1,
    parameter int unsigned NR_BITS     = 5,
    parameter int unsigned OP_BITS     = 4,
    parameter int unsigned MOD_BITS    = 3,
    localparam int unsigned NUM_PKTS   = NUM_THREADS / NUM_LANES,
    localparam int unsigned PID_WIDTH  = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [UUID_WIDTH-1:0]        in_uuid,
    input  logic [NW_WIDTH-1:0]          in_wid,
    input  logic [XLEN-1:0]              in_PC,
    input  logic [OP_BITS-1:0]           in_op_type,
    input  logic [MOD_BITS-1:0]          in_op_mod,
    input  logic [NR_BITS-1:0]           in_rd,
    input  logic                         in_wb,
    input  logic [NUM_THREADS-1:0]       in_tmask,
    input  logic [NUM_THREADS*XLEN-1:0]  in_rs1_data,
    input  logic [NUM_THREADS*XLEN-1:0]  in_rs2_data,
    input  logic [NUM_THREADS*XLEN-1:0]  in_rs3_data,

    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [UUID_WIDTH-1:0]        out_uuid,
    output logic [NW_WIDTH-1:0]          out_wid,
    output logic [XLEN-1:0]              out_PC,
    output logic [OP_BITS-1:0]           out_op_type,
    output logic [MOD_BITS-1:0]          out_op_mod,
    output logic [NR_BITS-1:0]           out_rd,
    output logic                         out_wb,
    output logic [NUM_LANES-1:0]         out_tmask,
    output logic [NUM_LANES*XLEN-1:0]    out_rs1_data,
    output logic [NUM_LANES*XLEN-1:0]    out_rs2_data,
    output logic [NUM_LANES*XLEN-1:0]    out_rs3_data,
    output logic [PID_WIDTH-1:0]         out_pid,
    output logic                         out_sop,
    output logic                         out_eop
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                  state_q;
    logic [PID_WIDTH-1:0]    pid_q;
    logic                    sop_q;
    logic [NUM_PKTS-1:0]     bm_q;

    logic [UUID_WIDTH-1:0]       uuid_q;
    logic [NW_WIDTH-1:0]         wid_q;
    logic [XLEN-1:0]             pc_q;
    logic [OP_BITS-1:0]          op_type_q;
    logic [MOD_BITS-1:0]         op_mod_q;
    logic [NR_BITS-1:0]          rd_q;
    logic                        wb_q;
    logic [NUM_THREADS-1:0]      tmask_q;
    logic [NUM_THREADS*XLEN-1:0] rs1_q;
    logic [NUM_THREADS*XLEN-1:0] rs2_q;
    logic [NUM_THREADS*XLEN-1:0] rs3_q;

    logic [NUM_PKTS-1:0]  in_bm;
    logic [PID_WIDTH-1:0] first_pid;
    logic [PID_WIDTH-1:0] next_pid;
    logic                 has_next;
    logic                 send;
    logic                 fire;
    logic                 last_fire;
    logic                 accept;

    always_comb begin
        for (int p = 0; p < int'(NUM_PKTS); p++) begin
            in_bm[p] = |in_tmask[p*NUM_LANES +: NUM_LANES];
        end
    end

    // Lowest non-empty block; stays 0 when the whole mask is empty.
    always_comb begin
        first_pid = '0;
        for (int p = int'(NUM_PKTS) - 1; p >= 0; p--) begin
            if (in_bm[p]) begin
                first_pid = PID_WIDTH'(p);
            end
        end
    end

    // Nearest non-empty block above the current one; none means this packet is the last.
    always_comb begin
        next_pid = pid_q;
        has_next = 1'b0;
        for (int p = int'(NUM_PKTS) - 1; p >= 0; p--) begin
            if (bm_q[p] && (PID_WIDTH'(p) > pid_q)) begin
                next_pid = PID_WIDTH'(p);
                has_next = 1'b1;
            end
        end
    end

    assign send      = (state_q == StSend);
    assign fire      = send & out_ready;
    assign last_fire = fire & ~has_next;
    assign in_ready  = reset & (~send | last_fire);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pid_q   <= '0;
            sop_q   <= 1'b0;
            bm_q    <= '0;
        end else if (accept) begin
            state_q <= StSend;
            pid_q   <= first_pid;
            sop_q   <= 1'b1;
            bm_q    <= in_bm;
        end else if (last_fire) begin
            state_q <= StIdle;
            pid_q   <= '0;
            sop_q   <= 1'b0;
        end else if (fire) begin
            pid_q   <= next_pid;
            sop_q   <= 1'b0;
        end
    end

    // Hold buffer only loads on accept, so it is frozen for the whole SEND sequence.
    always_ff @(posedge clk) begin
        if (accept) begin
            uuid_q    <= in_uuid;
            wid_q     <= in_wid;
            pc_q      <= in_PC;
            op_type_q <= in_op_type;
            op_mod_q  <= in_op_mod;
            rd_q      <= in_rd;
            wb_q      <= in_wb;
            tmask_q   <= in_tmask;
            rs1_q     <= in_rs1_data;
            rs2_q     <= in_rs2_data;
            rs3_q     <= in_rs3_data;
        end
    end

    assign out_valid    = send;
    assign out_pid      = pid_q;
    assign out_sop      = sop_q;
    assign out_eop      = send & ~has_next;
    assign out_uuid     = uuid_q;
    assign out_wid      = wid_q;
    assign out_PC       = pc_q;
    assign out_op_type  = op_type_q;
    assign out_op_mod   = op_mod_q;
    assign out_rd       = rd_q;
    assign out_wb       = wb_q;
    assign out_tmask    = tmask_q[pid_q*NUM_LANES +: NUM_LANES];
    assign out_rs1_data = rs1_q[pid_q*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign out_rs2_data = rs2_q[pid_q*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign out_rs3_data = rs3_q[pid_q*NUM_LANES*XLEN +: NUM_LANES*XLEN];

endmodule

// File: tb/tb_vx_fu_lane_dispatcher.sv
// Directed bench for vx_fu_lane_dispatcher: one NUM_LANES=1 instance (a_*) and one
// NUM_LANES=2 instance (b_*) sharing clock and reset.
module tb_vx_fu_lane_dispatcher;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] lane_a [4] = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003};
    logic [31:0] lane_b [4] = '{32'hB000_0010, 32'hB000_0011, 32'hB000_0012, 32'hB000_0013};

    // Instance A: 4 threads, 1 lane
    logic         a_in_valid, a_in_ready, a_in_wb, a_out_valid, a_out_ready, a_out_wb;
    logic [1:0]   a_in_uuid, a_in_wid, a_out_uuid, a_out_wid, a_out_pid;
    logic [31:0]  a_in_pc, a_out_pc;
    logic [3:0]   a_in_op, a_out_op, a_in_tmask;
    logic [2:0]   a_in_mod, a_out_mod;
    logic [4:0]   a_in_rd, a_out_rd;
    logic [127:0] a_in_rs1, a_in_rs2, a_in_rs3;
    logic [0:0]   a_out_tmask;
    logic [31:0]  a_out_rs1, a_out_rs2, a_out_rs3;
    logic         a_out_sop, a_out_eop;

    // Instance B: 4 threads, 2 lanes
    logic         b_in_valid, b_in_ready, b_in_wb, b_out_valid, b_out_ready, b_out_wb;
    logic [0:0]   b_in_uuid, b_out_uuid, b_out_pid;
    logic [1:0]   b_in_wid, b_out_wid, b_out_tmask;
    logic [31:0]  b_in_pc, b_out_pc;
    logic [3:0]   b_in_op, b_out_op, b_in_tmask;
    logic [2:0]   b_in_mod, b_out_mod;
    logic [4:0]   b_in_rd, b_out_rd;
    logic [127:0] b_in_rs1, b_in_rs2, b_in_rs3;
    logic [63:0]  b_out_rs1, b_out_rs2, b_out_rs3;
    logic         b_out_sop, b_out_eop;

    vx_fu_lane_dispatcher #(.NUM_THREADS(4), .NUM_LANES(1), .UUID_WIDTH(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_uuid(a_in_uuid), .in_wid(a_in_wid),
        .in_PC(a_in_pc), .in_op_type(a_in_op), .in_op_mod(a_in_mod), .in_rd(a_in_rd),
        .in_wb(a_in_wb), .in_tmask(a_in_tmask), .in_rs1_data(a_in_rs1),
        .in_rs2_data(a_in_rs2), .in_rs3_data(a_in_rs3),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_uuid(a_out_uuid),
        .out_wid(a_out_wid), .out_PC(a_out_pc), .out_op_type(a_out_op), .out_op_mod(a_out_mod),
        .out_rd(a_out_rd), .out_wb(a_out_wb), .out_tmask(a_out_tmask),
        .out_rs1_data(a_out_rs1), .out_rs2_data(a_out_rs2), .out_rs3_data(a_out_rs3),
        .out_pid(a_out_pid), .out_sop(a_out_sop), .out_eop(a_out_eop)
    );

    vx_fu_lane_dispatcher #(.NUM_THREADS(4), .NUM_LANES(2)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_uuid(b_in_uuid), .in_wid(b_in_wid),
        .in_PC(b_in_pc), .in_op_type(b_in_op), .in_op_mod(b_in_mod), .in_rd(b_in_rd),
        .in_wb(b_in_wb), .in_tmask(b_in_tmask), .in_rs1_data(b_in_rs1),
        .in_rs2_data(b_in_rs2), .in_rs3_data(b_in_rs3),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_uuid(b_out_uuid),
        .out_wid(b_out_wid), .out_PC(b_out_pc), .out_op_type(b_out_op), .out_op_mod(b_out_mod),
        .out_rd(b_out_rd), .out_wb(b_out_wb), .out_tmask(b_out_tmask),
        .out_rs1_data(b_out_rs1), .out_rs2_data(b_out_rs2), .out_rs3_data(b_out_rs3),
        .out_pid(b_out_pid), .out_sop(b_out_sop), .out_eop(b_out_eop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a_operands();
        a_in_rs1 = {lane_a[3], lane_a[2], lane_a[1], lane_a[0]};
        a_in_rs2 = ~a_in_rs1;
        a_in_rs3 = {lane_a[3] + 32'd1, lane_a[2] + 32'd1, lane_a[1] + 32'd1, lane_a[0] + 32'd1};
    endtask

    task automatic test_reset();
        logic [15:0] got;
        #2;
        n_checks++;
        got = {a_out_valid, a_out_pid, a_out_sop, a_out_eop, a_in_ready,
               b_out_valid, b_out_pid, b_out_sop, b_out_eop, b_in_ready};
        if (got !== 16'h0) begin
            n_fails++;
            $display("FAIL reset_outputs got=%h exp=0000", got);
        end
        #5 reset = 1'b1;
        tick();
        n_checks++;
        got = {12'h0, a_out_valid, a_in_ready, b_out_valid, b_in_ready};
        if (got !== 16'b0101) begin
            n_fails++;
            $display("FAIL reset_release_idle got=%b exp=0101", got[3:0]);
        end
    endtask

    task automatic test_full_mask();
        logic [127:0] got, exp;
        a_in_uuid = 2'd1; a_in_wid = 2'd2; a_in_pc = 32'h8000_0040; a_in_op = 4'h5;
        a_in_mod = 3'h3; a_in_rd = 5'd17; a_in_wb = 1'b1; a_in_tmask = 4'b1111;
        load_a_operands();
        a_out_ready = 1'b1;
        a_in_valid = 1'b1;
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL full_idle_ready got=%b exp=1", a_in_ready);
        end
        tick();
        a_in_valid = 1'b0;
        #1;
        n_checks++;
        got = {a_out_uuid, a_out_wid, a_out_pc, a_out_op, a_out_mod, a_out_rd, a_out_wb};
        exp = {2'd1, 2'd2, 32'h8000_0040, 4'h5, 3'h3, 5'd17, 1'b1};
        if (got !== exp) begin
            n_fails++;
            $display("FAIL full_tag_passthrough got=%h exp=%h", got, exp);
        end
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            got = {a_out_valid, a_out_pid, a_out_sop, a_out_eop, a_in_ready, a_out_tmask,
                   a_out_rs1, a_out_rs2, a_out_rs3};
            exp = {1'b1, 2'(p), p == 0, p == 3, p == 3, 1'b1,
                   lane_a[p], ~lane_a[p], lane_a[p] + 32'd1};
            if (got !== exp) begin
                n_fails++;
                $display("FAIL full_pkt pid=%0d got=%h exp=%h", p, got, exp);
            end
            tick();
            #1;
        end
        n_checks++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            n_fails++;
            $display("FAIL full_return_idle got=%b exp=01", {a_out_valid, a_in_ready});
        end
    endtask

    task automatic test_sparse();
        logic [127:0] got, exp;
        a_in_tmask = 4'b0101;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        #1;
        n_checks++;
        got = {a_out_valid, a_out_pid, a_out_sop, a_out_eop, a_in_ready, a_out_tmask, a_out_rs1};
        exp = {1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, lane_a[0]};
        if (got !== exp) begin
            n_fails++;
            $display("FAIL sparse_pid0 got=%h exp=%h", got, exp);
        end
        tick();
        #1;
        n_checks++;
        got = {a_out_valid, a_out_pid, a_out_sop, a_out_eop, a_in_ready, a_out_tmask, a_out_rs1};
        exp = {1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, lane_a[2]};
        if (got !== exp) begin
            n_fails++;
            $display("FAIL sparse_pid2 got=%h exp=%h", got, exp);
        end
        tick();
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL sparse_done got=%b exp=0", a_out_valid);
        end
    endtask

    task automatic test_empty();
        logic [7:0] got;
        a_in_tmask = 4'b0000;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        #1;
        n_checks++;
        got = {2'b0, a_out_valid, a_out_pid, a_out_sop, a_out_eop, a_out_tmask};
        if (got !== 8'b00_1_00_1_1_0) begin
            n_fails++;
            $display("FAIL empty_pkt got=%b exp=00100110", got);
        end
        tick();
        #1;
        n_checks++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            n_fails++;
            $display("FAIL empty_idle got=%b exp=01", {a_out_valid, a_in_ready});
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] got, exp;
        a_in_uuid = 2'd0;
        a_in_tmask = 4'b1111;
        load_a_operands();
        a_in_valid = 1'b1;
        tick();
        // Next instruction presented while the first is still sending.
        a_in_uuid = 2'd1;
        a_in_tmask = 4'b0010;
        a_in_rs1 = '0;
        #1;
        n_checks++;
        got = {a_out_valid, a_out_pid, a_out_sop, a_in_ready, a_out_rs1};
        exp = {1'b1, 2'd0, 1'b1, 1'b0, lane_a[0]};
        if (got !== exp) begin
            n_fails++;
            $display("FAIL bp_pid0 got=%h exp=%h", got, exp);
        end
        tick();
        a_out_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) a_out_ready = 1'b1;
            n_checks++;
            got = {a_out_valid, a_out_uuid, a_out_pid, a_out_sop, a_out_eop, a_in_ready,
                   a_out_tmask, a_out_rs1, a_out_rs2};
            exp = {1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, lane_a[1], ~lane_a[1]};
            if (got !== exp) begin
                n_fails++;
                $display("FAIL bp_stall cycle=%0d got=%h exp=%h", i, got, exp);
            end
            tick();
            #1;
        end
        n_checks++;
        got = {a_out_valid, a_out_pid, a_out_eop, a_in_ready, a_out_rs1};
        exp = {1'b1, 2'd2, 1'b0, 1'b0, lane_a[2]};
        if (got !== exp) begin
            n_fails++;
            $display("FAIL bp_pid2 got=%h exp=%h", got, exp);
        end
        tick();
        #1;
        n_checks++;
        got = {a_out_valid, a_out_uuid, a_out_pid, a_out_eop, a_in_ready, a_out_rs1};
        exp = {1'b1, 2'd0, 2'd3, 1'b1, 1'b1, lane_a[3]};
        if (got !== exp) begin
            n_fails++;
            $display("FAIL bp_pid3 got=%h exp=%h", got, exp);
        end
        tick();
        a_in_valid = 1'b0;
        #1;
        n_checks++;
        got = {a_out_valid, a_out_uuid, a_out_pid, a_out_sop, a_out_eop, a_out_rs1};
        exp = {1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 32'h0};
        if (got !== exp) begin
            n_fails++;
            $display("FAIL bp_next_instr got=%h exp=%h", got, exp);
        end
        tick();
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL bp_idle got=%b exp=0", a_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] got, exp;
        a_in_uuid = 2'd1;
        a_in_tmask = 4'b1000;
        load_a_operands();
        a_in_valid = 1'b1;
        tick();
        a_in_uuid = 2'd2;
        a_in_tmask = 4'b0001;
        a_in_rs1 = {96'h0, 32'hC0DE_0002};
        #1;
        n_checks++;
        got = {a_out_valid, a_out_uuid, a_out_pid, a_out_sop, a_out_eop, a_in_ready, a_out_rs1};
        exp = {1'b1, 2'd1, 2'd3, 1'b1, 1'b1, 1'b1, lane_a[3]};
        if (got !== exp) begin
            n_fails++;
            $display("FAIL b2b_first got=%h exp=%h", got, exp);
        end
        tick();
        a_in_valid = 1'b0;
        #1;
        n_checks++;
        got = {a_out_valid, a_out_uuid, a_out_pid, a_out_sop, a_out_eop, a_in_ready, a_out_rs1};
        exp = {1'b1, 2'd2, 2'd0, 1'b1, 1'b1, 1'b1, 32'hC0DE_0002};
        if (got !== exp) begin
            n_fails++;
            $display("FAIL b2b_second got=%h exp=%h", got, exp);
        end
        tick();
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL b2b_idle got=%b exp=0", a_out_valid);
        end
    endtask

    task automatic test_wide();
        logic [127:0] got, exp;
        b_in_tmask = 4'b1100;
        b_in_rs1 = {lane_b[3], lane_b[2], lane_b[1], lane_b[0]};
        b_out_ready = 1'b1;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        #1;
        n_checks++;
        got = {b_out_valid, b_out_pid, b_out_sop, b_out_eop, b_out_tmask, b_out_rs1};
        exp = {1'b1, 1'b1, 1'b1, 1'b1, 2'b11, lane_b[3], lane_b[2]};
        if (got !== exp) begin
            n_fails++;
            $display("FAIL wide_pkt got=%h exp=%h", got, exp);
        end
        tick();
        #1;
        n_checks++;
        if ({b_out_valid, b_in_ready} !== 2'b01) begin
            n_fails++;
            $display("FAIL wide_idle got=%b exp=01", {b_out_valid, b_in_ready});
        end
        // Same instruction again, reset pulled low while the packet is pending.
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        #1;
        n_checks++;
        if ({b_out_valid, b_out_pid} !== 2'b11) begin
            n_fails++;
            $display("FAIL wide_pre_reset got=%b exp=11", {b_out_valid, b_out_pid});
        end
        reset = 1'b0;
        #1;
        n_checks++;
        got = {124'h0, b_out_valid, b_out_sop, b_out_eop, b_in_ready};
        if (got !== 128'h0) begin
            n_fails++;
            $display("FAIL wide_async_reset got=%b exp=0000", got[3:0]);
        end
        #1 reset = 1'b1;
        b_out_ready = 1'b1;
        tick();
        n_checks++;
        if ({b_out_valid, b_in_ready} !== 2'b01) begin
            n_fails++;
            $display("FAIL wide_after_reset got=%b exp=01", {b_out_valid, b_in_ready});
        end
        b_in_tmask = 4'b0011;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        #1;
        n_checks++;
        got = {b_out_valid, b_out_pid, b_out_sop, b_out_eop, b_out_tmask, b_out_rs1};
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 2'b11, lane_b[1], lane_b[0]};
        if (got !== exp) begin
            n_fails++;
            $display("FAIL wide_post_reset_pkt got=%h exp=%h", got, exp);
        end
        tick();
        #1;
        n_checks++;
        if (b_out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL wide_final_idle got=%b exp=0", b_out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_uuid = '0; a_in_wid = '0; a_in_pc = '0;
        a_in_op = '0; a_in_mod = '0; a_in_rd = '0; a_in_wb = 1'b0; a_in_tmask = '0;
        a_in_rs1 = '0; a_in_rs2 = '0; a_in_rs3 = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_uuid = '0; b_in_wid = '0; b_in_pc = '0;
        b_in_op = '0; b_in_mod = '0; b_in_rd = '0; b_in_wb = 1'b0; b_in_tmask = '0;
        b_in_rs1 = '0; b_in_rs2 = '0; b_in_rs3 = '0;
        test_reset();
        test_full_mask();
        test_sparse();
        test_empty();
        test_backpressure();
        test_back_to_back();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
